// File: rtl/write_size_adapter.sv
// ---------------------------------------------------------------------------------------------
// write_size_adapter
//
// Converts byte/half-word/word writes at any byte alignment into one or two aligned 32-bit word
// writes with big-endian byte lanes. A request is placed MSB-first into a 64-bit window made of
// words {A, A+1}, starting at window byte o = byte_wr_addr[1:0]. If the bytes spill past the
// first word, a second write to A+1 follows in the next cycle. While that second write is still
// pending, wr_ready is held low.
//
// Ports
//   clk           in   single clock, rising edge
//   rst_n         in   synchronous active-low reset
//   byte_wr_addr  in   byte address of the request, any alignment
//   transfer_sz   in   2'b00 word, 2'b01 half-word, 2'b10 byte, 2'b11 invalid
//   wr_data       in   right-justified write data
//   wr_valid      in   request valid
//   wr_ready      out  request accepted when wr_valid & wr_ready
//   word_wr_addr  out  word address to the 32-bit memory
//   word_wr_data  out  word data; disabled lanes are zero
//   word_wr_be    out  byte enables, bit 3 = lane [31:24]
//   word_wr_en    out  memory write strobe
//   err           out  one-cycle error pulse
//
// Configuration macro
//   WSA_ADDR_WRAP_EN  When defined, A+1 wraps from the top word to word 0. When undefined, a
//                     spanning request at the top word writes its first half only and pulses
//                     err alongside that write.
//
// All outputs are registered. Outputs appear one cycle after acceptance.
// ---------------------------------------------------------------------------------------------

module write_size_adapter #(
    parameter int unsigned BYTE_ADDR_WIDTH = 12
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [BYTE_ADDR_WIDTH-1:0] byte_wr_addr,
    input  logic [1:0]                 transfer_sz,
    input  logic [31:0]                wr_data,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    output logic [BYTE_ADDR_WIDTH-3:0] word_wr_addr,
    output logic [31:0]                word_wr_data,
    output logic [3:0]                 word_wr_be,
    output logic                       word_wr_en,
    output logic                       err
);

    localparam int unsigned WordAddrWidth = BYTE_ADDR_WIDTH - 2;

`ifdef WSA_ADDR_WRAP_EN
    localparam bit AddrWrapEn = 1'b1;
`else
    localparam bit AddrWrapEn = 1'b0;
`endif

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StWr1  = 2'b01,
        StWr2  = 2'b10
    } state_e;

    // -----------------------------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------------------------
    state_e                   state_q, state_d;
    logic                     span_q, span_d;           // second half pending (only in StWr1)
    logic [WordAddrWidth-1:0] pend_addr_q, pend_addr_d;
    logic [31:0]              pend_data_q, pend_data_d;
    logic [3:0]               pend_be_q, pend_be_d;

    logic                     wr_ready_q, wr_ready_d;
    logic [WordAddrWidth-1:0] addr_q, addr_d;
    logic [31:0]              data_q, data_d;
    logic [3:0]               be_q, be_d;
    logic                     en_q, en_d;
    logic                     err_q, err_d;

    // -----------------------------------------------------------------------------------------
    // Request decode
    // -----------------------------------------------------------------------------------------
    logic [1:0]               req_off;
    logic [WordAddrWidth-1:0] req_word;
    logic [WordAddrWidth-1:0] req_word_next;
    logic [31:0]              req_left;     // data bytes left-justified, MSB first
    logic [3:0]               req_mask;     // lanes occupied by left-justified data
    logic [63:0]              req_win;
    logic [7:0]               req_be8;
    logic                     req_span;
    logic                     req_top;
    logic                     req_invalid;
    logic                     accept;

    assign req_off       = byte_wr_addr[1:0];
    assign req_word      = byte_wr_addr[BYTE_ADDR_WIDTH-1:2];
    // Natural modulo wrap; the no-wrap build blocks the top-word case separately.
    assign req_word_next = req_word + WordAddrWidth'(1);

    always_comb begin
        req_left = 32'h0;
        req_mask = 4'b0000;
        unique case (transfer_sz)
            2'b00: begin
                req_left = wr_data;
                req_mask = 4'b1111;
            end
            2'b01: begin
                req_left = {wr_data[15:0], 16'h0};
                req_mask = 4'b1100;
            end
            2'b10: begin
                req_left = {wr_data[7:0], 24'h0};
                req_mask = 4'b1000;
            end
            default: begin
                req_left = 32'h0;
                req_mask = 4'b0000;
            end
        endcase
    end

    // Shift the left-justified bytes right by o byte lanes across the 64-bit window.
    assign req_win     = {req_left, 32'h0} >> {req_off, 3'b000};
    assign req_be8     = {req_mask, 4'b0000} >> req_off;
    assign req_span    = |req_be8[3:0];
    assign req_top     = &req_word;
    assign req_invalid = (transfer_sz == 2'b11);
    assign accept      = wr_valid & wr_ready_q;

    // -----------------------------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------------------------
    always_comb begin
        state_d     = StIdle;
        span_d      = 1'b0;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        pend_be_d   = pend_be_q;
        wr_ready_d  = 1'b1;
        addr_d      = '0;
        data_d      = 32'h0;
        be_d        = 4'b0000;
        en_d        = 1'b0;
        err_d       = 1'b0;

        if (state_q == StWr1 && span_q) begin
            // wr_ready was low this cycle, so nothing can be accepted here.
            state_d = StWr2;
            addr_d  = pend_addr_q;
            data_d  = pend_data_q;
            be_d    = pend_be_q;
            en_d    = 1'b1;
        end else if (accept) begin
            if (req_invalid) begin
                err_d = 1'b1;
            end else begin
                state_d     = StWr1;
                addr_d      = req_word;
                data_d      = req_win[63:32];
                be_d        = req_be8[7:4];
                en_d        = 1'b1;
                pend_addr_d = req_word_next;
                pend_data_d = req_win[31:0];
                pend_be_d   = req_be8[3:0];
                if (req_span) begin
                    if (AddrWrapEn || !req_top) begin
                        span_d     = 1'b1;
                        wr_ready_d = 1'b0;
                    end else begin
                        // No word beyond the top: drop the second half and flag it.
                        err_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            span_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= 32'h0;
            pend_be_q   <= 4'b0000;
            wr_ready_q  <= 1'b0;
            addr_q      <= '0;
            data_q      <= 32'h0;
            be_q        <= 4'b0000;
            en_q        <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            span_q      <= span_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            pend_be_q   <= pend_be_d;
            wr_ready_q  <= wr_ready_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            be_q        <= be_d;
            en_q        <= en_d;
            err_q       <= err_d;
        end
    end

    assign wr_ready     = wr_ready_q;
    assign word_wr_addr = addr_q;
    assign word_wr_data = data_q;
    assign word_wr_be   = be_q;
    assign word_wr_en   = en_q;
    assign err          = err_q;

endmodule

// File: tb/tb_write_size_adapter.sv
// Testbench for write_size_adapter: directed vector table, hand-written multi-cycle sequences,
// and random traffic checked cycle by cycle against a byte-level reference model.
module tb_write_size_adapter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] byte_wr_addr = '0;
    logic [1:0]  transfer_sz = 2'b00;
    logic [31:0] wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [9:0]  word_wr_addr;
    logic [31:0] word_wr_data;
    logic [3:0]  word_wr_be;
    logic        word_wr_en;
    logic        err;

    int pass_cnt = 0;
    int total_cnt = 0;

`ifdef WSA_ADDR_WRAP_EN
    localparam bit Wrap = 1'b1;
`else
    localparam bit Wrap = 1'b0;
`endif

    write_size_adapter #(.BYTE_ADDR_WIDTH(12)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .byte_wr_addr (byte_wr_addr),
        .transfer_sz  (transfer_sz),
        .wr_data      (wr_data),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .word_wr_addr (word_wr_addr),
        .word_wr_data (word_wr_data),
        .word_wr_be   (word_wr_be),
        .word_wr_en   (word_wr_en),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------ reference model
    logic        exp_en, exp_err, exp_ready;
    logic [9:0]  exp_addr;
    logic [31:0] exp_data;
    logic [3:0]  exp_be;
    bit          m_pend;
    logic [9:0]  m_paddr;
    logic [31:0] m_pdata;
    logic [3:0]  m_pbe;

    // Build the 8-byte window byte by byte from the size/offset rules.
    function automatic void model_win(input logic [11:0] a, input logic [1:0] sz,
                                      input logic [31:0] d, output logic [31:0] up,
                                      output logic [31:0] lo, output logic [3:0] beu,
                                      output logic [3:0] bel, output bit span);
        int n, o;
        logic [7:0] wb [8];
        bit en [8];
        n = (sz == 2'b00) ? 4 : (sz == 2'b01) ? 2 : 1;
        o = int'(a[1:0]);
        for (int i = 0; i < 8; i++) begin
            wb[i] = 8'h00;
            en[i] = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            wb[o+i] = d[8*(n-1-i) +: 8];
            en[o+i] = 1'b1;
        end
        up   = {wb[0], wb[1], wb[2], wb[3]};
        lo   = {wb[4], wb[5], wb[6], wb[7]};
        beu  = {en[0], en[1], en[2], en[3]};
        bel  = {en[4], en[5], en[6], en[7]};
        span = (o + n > 4);
    endfunction

    task automatic model_clear();
        exp_en = 0; exp_err = 0; exp_addr = '0; exp_data = '0; exp_be = '0;
    endtask

    // Check this cycle's outputs at the falling edge, then drive inputs for the next edge
    // and advance the model to what the outputs must be after that edge.
    task automatic step(input bit rst, input bit v, input logic [11:0] a, input logic [1:0] sz,
                        input logic [31:0] d);
        logic [31:0] up, lo;
        logic [3:0]  beu, bel;
        bit          span, top;
        @(negedge clk);
        chk("wr_ready", wr_ready, exp_ready);
        chk("word_wr_en", word_wr_en, exp_en);
        chk("word_wr_addr", word_wr_addr, exp_addr);
        chk("word_wr_data", word_wr_data, exp_data);
        chk("word_wr_be", word_wr_be, exp_be);
        chk("err", err, exp_err);
        rst_n = rst; wr_valid = v; byte_wr_addr = a; transfer_sz = sz; wr_data = d;
        model_clear();
        if (!rst) begin
            m_pend = 0;
            exp_ready = 0;
        end else begin
            if (v && exp_ready) begin
                m_pend = 0;
                if (sz == 2'b11) begin
                    exp_err = 1;
                end else begin
                    model_win(a, sz, d, up, lo, beu, bel, span);
                    top = (a[11:2] == 10'h3FF);
                    exp_en = 1; exp_addr = a[11:2]; exp_data = up; exp_be = beu;
                    if (span && (Wrap || !top)) begin
                        m_pend = 1;
                        m_paddr = (a[11:2] == 10'h3FF) ? 10'h000 : a[11:2] + 10'd1;
                        m_pdata = lo; m_pbe = bel;
                    end else if (span) begin
                        exp_err = 1;
                    end
                end
            end else if (m_pend) begin
                exp_en = 1; exp_addr = m_paddr; exp_data = m_pdata; exp_be = m_pbe;
                m_pend = 0;
            end
            exp_ready = !m_pend;
        end
    endtask

    // ------------------------------------------------------------------ directed table
    typedef struct {
        logic [11:0] addr;
        logic [1:0]  sz;
        logic [31:0] data;
        logic        en1;
        logic [9:0]  a1;
        logic [31:0] d1;
        logic [3:0]  be1;
        logic        err1;
        logic        rdy1;
        logic        en2;
        logic [9:0]  a2;
        logic [31:0] d2;
        logic [3:0]  be2;
    } vec_t;

    vec_t vecs [6];

    initial begin
        model_clear();
        exp_ready = 0;
        m_pend = 0;

        vecs[0] = '{12'h004, 2'b00, 32'hDEADBEEF, 1, 10'h001, 32'hDEADBEEF, 4'b1111, 0, 1,
                    0, 10'h000, 32'h0, 4'b0000};
        vecs[1] = '{12'h007, 2'b01, 32'h0000ABCD, 1, 10'h001, 32'h000000AB, 4'b0001, 0, 0,
                    1, 10'h002, 32'hCD000000, 4'b1000};
        if (Wrap)
            vecs[2] = '{12'hFFE, 2'b00, 32'h11223344, 1, 10'h3FF, 32'h00001122, 4'b0011, 0, 0,
                        1, 10'h000, 32'h33440000, 4'b1100};
        else
            vecs[2] = '{12'hFFE, 2'b00, 32'h11223344, 1, 10'h3FF, 32'h00001122, 4'b0011, 1, 1,
                        0, 10'h000, 32'h0, 4'b0000};
        vecs[3] = '{12'h123, 2'b11, 32'hCAFEF00D, 0, 10'h000, 32'h0, 4'b0000, 1, 1,
                    0, 10'h000, 32'h0, 4'b0000};
        vecs[4] = '{12'h001, 2'b10, 32'hAAAAAA55, 1, 10'h000, 32'h00550000, 4'b0100, 0, 1,
                    0, 10'h000, 32'h0, 4'b0000};
        vecs[5] = '{12'h00A, 2'b01, 32'hFFFF1234, 1, 10'h002, 32'h00001234, 4'b0011, 0, 1,
                    0, 10'h000, 32'h0, 4'b0000};

        // Reset state
        repeat (3) step(0, 0, '0, 2'b00, '0);
        step(1, 0, '0, 2'b00, '0);

        foreach (vecs[i]) begin
            step(1, 1, vecs[i].addr, vecs[i].sz, vecs[i].data);
            @(posedge clk); #1;
            chk("tbl_en1", word_wr_en, vecs[i].en1);
            chk("tbl_addr1", word_wr_addr, vecs[i].a1);
            chk("tbl_data1", word_wr_data, vecs[i].d1);
            chk("tbl_be1", word_wr_be, vecs[i].be1);
            chk("tbl_err1", err, vecs[i].err1);
            chk("tbl_rdy1", wr_ready, vecs[i].rdy1);
            step(1, 0, '0, 2'b00, '0);
            @(posedge clk); #1;
            chk("tbl_en2", word_wr_en, vecs[i].en2);
            chk("tbl_addr2", word_wr_addr, vecs[i].a2);
            chk("tbl_data2", word_wr_data, vecs[i].d2);
            chk("tbl_be2", word_wr_be, vecs[i].be2);
            chk("tbl_err2", err, 1'b0);
            step(1, 0, '0, 2'b00, '0);
        end

        // Back-to-back byte writes, no bubble
        step(1, 1, 12'h002, 2'b10, 32'h00000012);
        step(1, 1, 12'h003, 2'b10, 32'h00000034);
        #1;
        chk("b2b_en1", word_wr_en, 1'b1);
        chk("b2b_data1", word_wr_data, 32'h00001200);
        chk("b2b_be1", word_wr_be, 4'b0010);
        @(posedge clk); #1;
        chk("b2b_en2", word_wr_en, 1'b1);
        chk("b2b_addr2", word_wr_addr, 10'h000);
        chk("b2b_data2", word_wr_data, 32'h00000034);
        chk("b2b_be2", word_wr_be, 4'b0001);
        step(1, 0, '0, 2'b00, '0);
        step(1, 0, '0, 2'b00, '0);

        // Reset while the second half is pending
        step(1, 1, 12'h003, 2'b01, 32'h00005678);
        @(posedge clk); #1;
        chk("rst_first_en", word_wr_en, 1'b1);
        chk("rst_first_rdy", wr_ready, 1'b0);
        step(0, 0, '0, 2'b00, '0);
        @(posedge clk); #1;
        chk("rst_no_wr2", word_wr_en, 1'b0);
        chk("rst_rdy", wr_ready, 1'b0);
        chk("rst_data", word_wr_data, 32'h0);
        chk("rst_be", word_wr_be, 4'b0000);
        step(1, 0, '0, 2'b00, '0);
        step(1, 0, '0, 2'b00, '0);
        step(1, 0, '0, 2'b00, '0);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            logic [11:0] ra;
            logic [1:0]  rs;
            bit          rv, rr;
            ra = 12'($urandom);
            if ($urandom_range(0, 7) == 0) ra[11:2] = 10'h3FF;
            rs = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            rv = ($urandom_range(0, 9) < 7);
            rr = ($urandom_range(0, 99) != 0);
            step(rr, rv, ra, rs, $urandom);
        end
        step(1, 0, '0, 2'b00, '0);
        step(1, 0, '0, 2'b00, '0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/write_size_adapter.md
WRITE_SIZE_ADAPTER -- requirements
Module: write_size_adapter

Interface
REQ-001 SHALL have parameter BYTE_ADDR_WIDTH, default 12, the width of the byte address into packet memory.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port byte_wr_addr  input  BYTE_ADDR_WIDTH  byte address of the write; any alignment.
REQ-005 SHALL have port transfer_sz  input  2  size code: 2'b00 word, 2'b01 half-word, 2'b10 byte, 2'b11 invalid.
REQ-006 SHALL have port wr_data  input  32  write data, right-justified; unused upper bits ignored.
REQ-007 SHALL have port wr_valid  input  1  request valid.
REQ-008 SHALL have port wr_ready  output  1  request accepted on a cycle with wr_valid and wr_ready both high.
REQ-009 SHALL have port word_wr_addr  output  BYTE_ADDR_WIDTH-2  word address to the 32-bit memory.
REQ-010 SHALL have port word_wr_data  output  32  word data, big-endian byte lanes.
REQ-011 SHALL have port word_wr_be  output  4  byte enables; bit 3 is byte lane [31:24].
REQ-012 SHALL have port word_wr_en  output  1  memory write strobe.
REQ-013 SHALL have port err  output  1  one-cycle error pulse.

Function
REQ-014 SHALL use byte count n = 4/2/1 for W/H/B, offset o = byte_wr_addr[1:0] and word address A = byte_wr_addr[BYTE_ADDR_WIDTH-1:2].
REQ-015 SHALL form a 64-bit window {word A, word A+1}, place the n data bytes MSB-first starting at window byte o, and set enables only on those bytes.
REQ-016 SHALL classify a request as spanning when o+n > 4.
REQ-017 SHALL implement states IDLE, WR1 and WR2, with all outputs registered.
REQ-018 SHALL move to WR1 on acceptance at cycle T and drive word_wr_en=1 at T+1 with the upper window half to address A.
REQ-019 SHALL, for a spanning request, go WR1 -> WR2 and drive word_wr_en=1 at T+2 with the lower window half to address A+1.
REQ-020 SHALL hold wr_ready=0 only in WR1 with a spanning request pending; otherwise wr_ready=1 (out of reset).
REQ-021 SHALL, on acceptance while in WR1 (non-spanning) or WR2, go to WR1 with the new request, giving one word write per cycle with no bubble.
REQ-022 SHALL return to IDLE from WR1 (non-spanning) or WR2 when no request is accepted.
REQ-023 SHALL hold word_wr_en=0 and word_wr_be=4'b0000 in IDLE, and word_wr_data equal to 0 on disabled lanes.
REQ-024 SHALL accept transfer_sz=2'b11, perform no write (word_wr_en=0), and pulse err=1 at T+1.
REQ-025 SHALL keep err=0 in all other cases except REQ-028.

Reset
REQ-026 SHALL, while rst_n=0 at a clock edge, force state IDLE, wr_ready=0, word_wr_en=0, word_wr_be=0, word_wr_addr=0, word_wr_data=0 and err=0.
REQ-027 SHALL discard any pending second half when reset is asserted in WR1 or WR2; no write follows reset release.

Configuration
REQ-028 SHALL use macro WSA_ADDR_WRAP_EN: when defined, A+1 wraps modulo 2^(BYTE_ADDR_WIDTH-2) (top word -> word 0); when undefined, a spanning request at the top word writes the first half only, skips WR2, keeps wr_ready=1, and pulses err=1 in the same cycle as the first write.

Verification
REQ-029 SHALL cover: W at 0x004, data 0xDEADBEEF -> T+1: addr 0x001, data 0xDEADBEEF, be 4'b1111; wr_ready stays 1.
REQ-030 SHALL cover: H at 0x007, data 0x0000ABCD -> T+1: addr 0x001, data 0x000000AB, be 4'b0001, wr_ready=0; T+2: addr 0x002, data 0xCD000000, be 4'b1000.
REQ-031 SHALL cover: B at 0x002, data 0x00000012, then B at 0x003, data 0x34 on the next cycle -> consecutive writes: addr 0x000, 0x00001200, be 4'b0010; then 0x00000034, be 4'b0001.
REQ-032 SHALL cover: W at 0xFFE, data 0x11223344 -> T+1: addr 0x3FF, data 0x00001122, be 4'b0011; with WSA_ADDR_WRAP_EN, T+2: addr 0x000, data 0x33440000, be 4'b1100; without it, no T+2 write and err=1 at T+1.
REQ-033 SHALL cover: transfer_sz=2'b11 at any address -> no word_wr_en, err=1 for exactly one cycle.
REQ-034 SHALL cover: H at 0x003 accepted, rst_n=0 at T+1 -> no write at T+2; all outputs zero; after release, IDLE with wr_ready=1.
